// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-to-RAM boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WR,
    FIN,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  localparam int         LEN_BYTES  = 4;
  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WORD_MASK  = 4'b1111;

endpackage

// File: rtl/loader_if.sv
// Byte-stream handshake from the UART RX path plus the RAM write bus driven by the loader.
interface loader_if;

  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out;
  logic [31:0] address_out;
  logic        sel_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;

  modport master (
    input  rx_valid_in,
    input  rx_data_in,
    output rx_ready_out,
    output address_out,
    output sel_out,
    output write_mask_out,
    output write_value_out
  );

  modport slave (
    output rx_valid_in,
    output rx_data_in,
    input  rx_ready_out,
    input  address_out,
    input  sel_out,
    input  write_mask_out,
    input  write_value_out
  );

endinterface

// File: rtl/loader_word_asm.sv
// Collects little-endian bytes into 32-bit words; the first byte received lands in bits 7:0.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_q;
  logic [23:0] lanes_q;

  // The fourth byte bypasses the lane register so the word is ready in the accepting cycle.
  assign word_valid = byte_valid && (byte_idx_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_data, lanes_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else if (byte_valid) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      lanes_q    <= {byte_data, lanes_q[23:8]};
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Boot loader: length-prefixed UART byte image -> program RAM writes, then CPU reset release.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before completion.
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic     clk,
  input  logic     reset,
  loader_if.master bus,
  output logic     done_out,
  output logic     error_out,
  output logic     cpu_reset_out
);

  localparam int          CW    = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  loader_state_e state_q, state_d;
  logic          ready_q, ready_d;
  logic [1:0]    len_idx_q;
  logic [31:0]   n_words_q;
  logic [CW-1:0] word_cnt_q;
  logic [CW-1:0] word_cnt_inc;
  logic [31:0]   addr_q;
  logic          sel_q;
  logic [3:0]    mask_q;
  logic [31:0]   value_q;
  logic          accept;
  logic [31:0]   len_full;
  logic          word_valid;
  logic [31:0]   word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  assign accept       = bus.rx_valid_in && ready_q;
  assign len_full     = {bus.rx_data_in, n_words_q[31:8]};
  assign word_cnt_inc = word_cnt_q + CW'(1);

  loader_word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept && (state_q == DATA)),
    .byte_data  (bus.rx_data_in),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN: begin
        if (accept && (len_idx_q == 2'(LEN_BYTES - 1))) begin
          if (len_full > MAX_N)       state_d = ERR;
          else if (len_full == '0)    state_d = FIN;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) state_d = WR;
      end
      WR: begin
        if (32'(word_cnt_inc) == n_words_q) state_d = FIN;
        else                                state_d = DATA;
      end
      FIN: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = CHK;
`else
        state_d = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (bus.rx_data_in == xor_q) ? DONE : ERR;
      end
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
    // Ready is registered alongside the state so it is low during the write strobe and FIN.
    ready_d = (state_d != WR) && (state_d != FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LEN;
      ready_q    <= 1'b0;
      len_idx_q  <= '0;
      n_words_q  <= '0;
      word_cnt_q <= '0;
      addr_q     <= BASE_ADDR;
      sel_q      <= 1'b0;
      mask_q     <= '0;
      value_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      sel_q   <= 1'b0;
      mask_q  <= '0;
      value_q <= '0;
      if ((state_q == LEN) && accept) begin
        n_words_q <= len_full;
        len_idx_q <= len_idx_q + 2'd1;
      end
      if ((state_q == DATA) && word_valid) begin
        sel_q   <= 1'b1;
        mask_q  <= WORD_MASK;
        value_q <= word;
      end
      if (state_q == WR) begin
        addr_q     <= addr_q + 32'd4;
        word_cnt_q <= word_cnt_inc;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Only payload bytes feed the checksum; the length prefix is excluded.
  always_ff @(posedge clk) begin
    if (reset)                            xor_q <= '0;
    else if ((state_q == DATA) && accept) xor_q <= xor_q ^ bus.rx_data_in;
  end
`endif

  assign bus.rx_ready_out    = ready_q;
  assign bus.address_out     = addr_q;
  assign bus.sel_out         = sel_q;
  assign bus.write_mask_out  = mask_q;
  assign bus.write_value_out = value_q;

  assign done_out      = (state_q == DONE);
  assign error_out     = (state_q == ERR);
  assign cpu_reset_out = (state_q != DONE);

endmodule
